// File: rtl/cu_pkg.sv
// Shared opcodes, ALU codes, state encoding and strobe bundle for ezRISC control.
// CU_MULDIV_EN enables the mul/div execute sequence.
package cu_pkg;

  localparam int OPC_BITS = 5;
  typedef logic [OPC_BITS-1:0] opc_t;

  localparam opc_t OP_LD   = 5'd0;
  localparam opc_t OP_LDI  = 5'd1;
  localparam opc_t OP_ST   = 5'd2;
  localparam opc_t OP_ADD  = 5'd3;
  localparam opc_t OP_SUB  = 5'd4;
  localparam opc_t OP_SHR  = 5'd5;
  localparam opc_t OP_SHL  = 5'd6;
  localparam opc_t OP_ROR  = 5'd7;
  localparam opc_t OP_ROL  = 5'd8;
  localparam opc_t OP_AND  = 5'd9;
  localparam opc_t OP_OR   = 5'd10;
  localparam opc_t OP_ADDI = 5'd11;
  localparam opc_t OP_ANDI = 5'd12;
  localparam opc_t OP_ORI  = 5'd13;
  localparam opc_t OP_MUL  = 5'd14;
  localparam opc_t OP_DIV  = 5'd15;
  localparam opc_t OP_NEG  = 5'd16;
  localparam opc_t OP_NOT  = 5'd17;
  localparam opc_t OP_BR   = 5'd18;
  localparam opc_t OP_JR   = 5'd19;
  localparam opc_t OP_JAL  = 5'd20;
  localparam opc_t OP_IN   = 5'd21;
  localparam opc_t OP_OUT  = 5'd22;
  localparam opc_t OP_MFHI = 5'd23;
  localparam opc_t OP_MFLO = 5'd24;
  localparam opc_t OP_NOP  = 5'd25;
  localparam opc_t OP_HALT = 5'd26;

  typedef logic [3:0] alu_t;

  localparam alu_t ALU_AND = 4'h0;
  localparam alu_t ALU_OR  = 4'h1;
  localparam alu_t ALU_ADD = 4'h2;
  localparam alu_t ALU_SUB = 4'h3;
  localparam alu_t ALU_SHR = 4'h4;
  localparam alu_t ALU_SHL = 4'h5;
  localparam alu_t ALU_ROR = 4'h6;
  localparam alu_t ALU_ROL = 4'h7;
  localparam alu_t ALU_MUL = 4'h8;
  localparam alu_t ALU_DIV = 4'h9;
  localparam alu_t ALU_NEG = 4'hA;
  localparam alu_t ALU_NOT = 4'hB;

  typedef enum logic [3:0] {
    S_RESET,
    S_PAUSE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALTED
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic read;
    logic write;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic z_low_out;
    logic z_high_out;
    logic hi_in;
    logic hi_out;
    logic lo_in;
    logic lo_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic c_out;
    logic con_in;
    logic inport_out;
    logic outport_in;
    alu_t alu_op;
  } ctl_t;

  function automatic alu_t alu_of(opc_t op);
    case (op)
      OP_SUB:  alu_of = ALU_SUB;
      OP_SHR:  alu_of = ALU_SHR;
      OP_SHL:  alu_of = ALU_SHL;
      OP_ROR:  alu_of = ALU_ROR;
      OP_ROL:  alu_of = ALU_ROL;
      OP_AND:  alu_of = ALU_AND;
      OP_OR:   alu_of = ALU_OR;
      OP_ANDI: alu_of = ALU_AND;
      OP_ORI:  alu_of = ALU_OR;
      OP_NEG:  alu_of = ALU_NEG;
      OP_NOT:  alu_of = ALU_NOT;
`ifdef CU_MULDIV_EN
      OP_MUL:  alu_of = ALU_MUL;
      OP_DIV:  alu_of = ALU_DIV;
`endif
      default: alu_of = ALU_ADD;
    endcase
  endfunction

  // Index of the final T step; 2 means the opcode has no execute steps.
  function automatic logic [2:0] last_step(opc_t op);
    case (op)
      OP_LD, OP_ST:   last_step = 3'd7;
      OP_BR:          last_step = 3'd6;
      OP_NEG, OP_NOT: last_step = 3'd4;
      OP_JR, OP_IN, OP_OUT,
      OP_MFHI, OP_MFLO: last_step = 3'd3;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV: last_step = 3'd6;
`endif
      default: begin
        if (op <= OP_ORI) last_step = 3'd5;
        else              last_step = 3'd2;
      end
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Pure decode of {state, latched opcode, con_out} into datapath strobes.
// CU_MULDIV_EN adds the mul/div step decode.
module cu_decode
  import cu_pkg::*;
(
  input  state_t     state,
  input  opc_t       opc,
  input  logic       con_out,
  output ctl_t       ctl
);

  logic is_r;
  logic is_i;
  logic is_un;
  logic is_md;
  logic is_ldst;

  assign is_r    = (opc >= OP_ADD) && (opc <= OP_OR);
  assign is_i    = (opc >= OP_ADDI) && (opc <= OP_ORI);
  assign is_un   = (opc == OP_NEG) || (opc == OP_NOT);
  assign is_ldst = (opc == OP_LD) || (opc == OP_ST);
`ifdef CU_MULDIV_EN
  assign is_md   = (opc == OP_MUL) || (opc == OP_DIV);
`else
  assign is_md   = 1'b0;
`endif

  always_comb begin
    ctl = '0;
    unique case (state)
      S_T0: begin
        ctl.pc_out = 1'b1;
        ctl.mar_in = 1'b1;
        ctl.inc_pc = 1'b1;
        ctl.z_in   = 1'b1;
        ctl.alu_op = ALU_ADD;
      end
      S_T1: begin
        ctl.z_low_out = 1'b1;
        ctl.pc_in     = 1'b1;
        ctl.read      = 1'b1;
        ctl.mdr_in    = 1'b1;
      end
      S_T2: begin
        ctl.mdr_out = 1'b1;
        ctl.ir_in   = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          is_r, is_i: begin
            ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
          end
          is_ldst, (opc == OP_LDI): begin
            ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1;
          end
          is_un: begin
            ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1;
            ctl.alu_op = alu_of(opc);
          end
          is_md: begin
            ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
          end
          (opc == OP_BR): begin
            ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1;
          end
          (opc == OP_JR): begin
            ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1;
          end
          (opc == OP_IN): begin
            ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
          end
          (opc == OP_OUT): begin
            ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_in = 1'b1;
          end
          (opc == OP_MFHI): begin
            ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
          end
          (opc == OP_MFLO): begin
            ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          is_r, is_md: begin
            ctl.grc   = is_r;
            ctl.grb   = is_md;
            ctl.r_out = 1'b1; ctl.z_in = 1'b1;
            ctl.alu_op = alu_of(opc);
          end
          is_i, is_ldst, (opc == OP_LDI): begin
            ctl.c_out = 1'b1; ctl.z_in = 1'b1;
            ctl.alu_op = alu_of(opc);
          end
          is_un: begin
            ctl.z_low_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
          end
          (opc == OP_BR): begin
            ctl.pc_out = 1'b1; ctl.y_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          is_r, is_i, (opc == OP_LDI): begin
            ctl.z_low_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
          end
          is_ldst: begin
            ctl.z_low_out = 1'b1; ctl.mar_in = 1'b1;
          end
          is_md: begin
            ctl.z_low_out = 1'b1; ctl.lo_in = 1'b1;
          end
          (opc == OP_BR): begin
            ctl.c_out = 1'b1; ctl.z_in = 1'b1;
            ctl.alu_op = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          (opc == OP_LD): begin
            ctl.read = 1'b1; ctl.mdr_in = 1'b1;
          end
          (opc == OP_ST): begin
            ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1;
          end
          is_md: begin
            ctl.z_high_out = 1'b1; ctl.hi_in = 1'b1;
          end
          (opc == OP_BR): begin
            ctl.z_low_out = con_out; ctl.pc_in = con_out;
          end
          default: ;
        endcase
      end
      S_T7: begin
        unique case (1'b1)
          (opc == OP_LD): begin
            ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
          end
          (opc == OP_ST): ctl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// ezRISC hardwired sequencer: state register, opcode latch and stop handling.
// Define CU_MULDIV_EN to execute mul/div; otherwise they run as nop.
module control_unit
  import cu_pkg::*;
#(
  parameter int OPC_W = 5
)
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ir,
  input  logic        con_out,
  input  logic        stop,
  output logic        run,
  output logic        pc_out,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        read,
  output logic        write,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        z_low_out,
  output logic        z_high_out,
  output logic        hi_in,
  output logic        hi_out,
  output logic        lo_in,
  output logic        lo_out,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_in,
  output logic        r_out,
  output logic        ba_out,
  output logic        c_out,
  output logic        con_in,
  output logic        inport_out,
  output logic        outport_in,
  output logic [3:0]  alu_op
);

  state_t           state_q;
  state_t           state_d;
  state_t           bnd;
  logic [OPC_W-1:0] opc_q;
  opc_t             ir_op;
  opc_t             op;
  logic [2:0]       last;
  ctl_t             ctl;
  logic             unused_ir;

  assign ir_op     = opc_t'(ir[31 -: OPC_W]);
  assign op        = opc_t'(opc_q);
  assign last      = last_step(op);
  assign bnd       = stop ? S_PAUSE : S_T0;
  assign unused_ir = ^ir[31-OPC_W:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T2) opc_q <= ir[31 -: OPC_W];
    end
  end

  // The opcode is not latched until T2 ends, so T2 decides from ir directly.
  always_comb begin
    state_d = S_RESET;
    unique case (state_q)
      S_RESET:  state_d = bnd;
      S_PAUSE:  state_d = bnd;
      S_T0:     state_d = S_T1;
      S_T1:     state_d = S_T2;
      S_T2: begin
        if (ir_op == OP_HALT)             state_d = S_HALTED;
        else if (last_step(ir_op) == 3'd2) state_d = bnd;
        else                              state_d = S_T3;
      end
      S_T3:     state_d = (last == 3'd3) ? bnd : S_T4;
      S_T4:     state_d = (last == 3'd4) ? bnd : S_T5;
      S_T5:     state_d = (last == 3'd5) ? bnd : S_T6;
      S_T6:     state_d = (last == 3'd6) ? bnd : S_T7;
      S_T7:     state_d = bnd;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RESET;
    endcase
  end

  assign run = (state_q >= S_T0) && (state_q <= S_T7);

  cu_decode u_dec (
    .state   (state_q),
    .opc     (op),
    .con_out (con_out),
    .ctl     (ctl)
  );

  assign pc_out     = ctl.pc_out;
  assign pc_in      = ctl.pc_in;
  assign inc_pc     = ctl.inc_pc;
  assign mar_in     = ctl.mar_in;
  assign mdr_in     = ctl.mdr_in;
  assign mdr_out    = ctl.mdr_out;
  assign read       = ctl.read;
  assign write      = ctl.write;
  assign ir_in      = ctl.ir_in;
  assign y_in       = ctl.y_in;
  assign z_in       = ctl.z_in;
  assign z_low_out  = ctl.z_low_out;
  assign z_high_out = ctl.z_high_out;
  assign hi_in      = ctl.hi_in;
  assign hi_out     = ctl.hi_out;
  assign lo_in      = ctl.lo_in;
  assign lo_out     = ctl.lo_out;
  assign gra        = ctl.gra;
  assign grb        = ctl.grb;
  assign grc        = ctl.grc;
  assign r_in       = ctl.r_in;
  assign r_out      = ctl.r_out;
  assign ba_out     = ctl.ba_out;
  assign c_out      = ctl.c_out;
  assign con_in     = ctl.con_in;
  assign inport_out = ctl.inport_out;
  assign outport_in = ctl.outport_in;
  assign alu_op     = ctl.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit.
// Observed word is {run, alu_op, 27 strobes}.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ir;
  logic        con_out;
  logic        stop;
  logic        run;
  logic        pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out;
  logic        read, write, ir_in, y_in, z_in, z_low_out, z_high_out;
  logic        hi_in, hi_out, lo_in, lo_out, gra, grb, grc;
  logic        r_in, r_out, ba_out, c_out, con_in;
  logic        inport_out, outport_in;
  logic [3:0]  alu_op;
  logic [31:0] obs;

  int tests = 0;
  int fails = 0;

  localparam logic [26:0] PC_OUT     = 27'd1 << 26;
  localparam logic [26:0] PC_IN      = 27'd1 << 25;
  localparam logic [26:0] INC_PC     = 27'd1 << 24;
  localparam logic [26:0] MAR_IN     = 27'd1 << 23;
  localparam logic [26:0] MDR_IN     = 27'd1 << 22;
  localparam logic [26:0] MDR_OUT    = 27'd1 << 21;
  localparam logic [26:0] READ       = 27'd1 << 20;
  localparam logic [26:0] WRITE      = 27'd1 << 19;
  localparam logic [26:0] IR_IN      = 27'd1 << 18;
  localparam logic [26:0] Y_IN       = 27'd1 << 17;
  localparam logic [26:0] Z_IN       = 27'd1 << 16;
  localparam logic [26:0] Z_LOW_OUT  = 27'd1 << 15;
  localparam logic [26:0] Z_HIGH_OUT = 27'd1 << 14;
  localparam logic [26:0] HI_IN      = 27'd1 << 13;
  localparam logic [26:0] HI_OUT     = 27'd1 << 12;
  localparam logic [26:0] LO_IN      = 27'd1 << 11;
  localparam logic [26:0] LO_OUT     = 27'd1 << 10;
  localparam logic [26:0] GRA        = 27'd1 << 9;
  localparam logic [26:0] GRB        = 27'd1 << 8;
  localparam logic [26:0] GRC        = 27'd1 << 7;
  localparam logic [26:0] R_IN       = 27'd1 << 6;
  localparam logic [26:0] R_OUT      = 27'd1 << 5;
  localparam logic [26:0] BA_OUT     = 27'd1 << 4;
  localparam logic [26:0] C_OUT      = 27'd1 << 3;
  localparam logic [26:0] CON_IN     = 27'd1 << 2;
  localparam logic [26:0] INPORT_OUT = 27'd1 << 1;
  localparam logic [26:0] OUTPORT_IN = 27'd1 << 0;

  control_unit #(.OPC_W(5)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ir         (ir),
    .con_out    (con_out),
    .stop       (stop),
    .run        (run),
    .pc_out     (pc_out),
    .pc_in      (pc_in),
    .inc_pc     (inc_pc),
    .mar_in     (mar_in),
    .mdr_in     (mdr_in),
    .mdr_out    (mdr_out),
    .read       (read),
    .write      (write),
    .ir_in      (ir_in),
    .y_in       (y_in),
    .z_in       (z_in),
    .z_low_out  (z_low_out),
    .z_high_out (z_high_out),
    .hi_in      (hi_in),
    .hi_out     (hi_out),
    .lo_in      (lo_in),
    .lo_out     (lo_out),
    .gra        (gra),
    .grb        (grb),
    .grc        (grc),
    .r_in       (r_in),
    .r_out      (r_out),
    .ba_out     (ba_out),
    .c_out      (c_out),
    .con_in     (con_in),
    .inport_out (inport_out),
    .outport_in (outport_in),
    .alu_op     (alu_op)
  );

  assign obs = {run, alu_op,
                pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out,
                read, write, ir_in, y_in, z_in, z_low_out,
                z_high_out, hi_in, hi_out, lo_in, lo_out,
                gra, grb, grc, r_in, r_out, ba_out, c_out,
                con_in, inport_out, outport_in};

  always #5 clk = ~clk;

  function automatic logic [31:0] ex(input logic [3:0] a,
                                     input logic [26:0] m);
    return {1'b1, a, m};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
    end
  endtask

  // Entered with the DUT in T0; leaves it one edge after T2.
  task automatic fetch(input logic [31:0] v, input string tag);
    chk({tag, "_t0"}, ex(4'h2, PC_OUT | MAR_IN | INC_PC | Z_IN));
    step();
    chk({tag, "_t1"}, ex(4'h0, Z_LOW_OUT | PC_IN | READ | MDR_IN));
    step();
    chk({tag, "_t2"}, ex(4'h0, MDR_OUT | IR_IN));
    ir = v;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    stop    = 1'b0;
    con_out = 1'b0;
    ir      = 32'h0;
    step();
    step();
    chk("reset", 32'h0);
    reset_n = 1'b1;
    step();

    fetch(32'h9880_0000, "jr");
    chk("jr_t3", ex(4'h0, GRA | R_OUT | PC_IN));
    step();

    con_out = 1'b1;
    fetch(32'h9000_0000, "br1");
    chk("br1_t3", ex(4'h0, GRA | R_OUT | CON_IN));
    step();
    chk("br1_t4", ex(4'h0, PC_OUT | Y_IN));
    step();
    chk("br1_t5", ex(4'h2, C_OUT | Z_IN));
    step();
    chk("br1_t6", ex(4'h0, Z_LOW_OUT | PC_IN));
    step();

    con_out = 1'b0;
    fetch(32'h9000_0000, "br0");
    step();
    step();
    step();
    chk("br0_t6", ex(4'h0, 27'd0));
    step();

    fetch(32'h0000_0000, "ld");
    chk("ld_t3", ex(4'h0, GRB | BA_OUT | Y_IN));
    step();
    chk("ld_t4", ex(4'h2, C_OUT | Z_IN));
    step();
    chk("ld_t5", ex(4'h0, Z_LOW_OUT | MAR_IN));
    step();
    chk("ld_t6", ex(4'h0, READ | MDR_IN));
    step();
    chk("ld_t7", ex(4'h0, MDR_OUT | GRA | R_IN));
    step();

    fetch(32'h1000_0000, "st");
    step();
    step();
    step();
    chk("st_t6", ex(4'h0, GRA | R_OUT | MDR_IN));
    step();
    chk("st_t7", ex(4'h0, WRITE));
    step();

    fetch(32'h1800_0000, "add");
    chk("add_t3", ex(4'h0, GRB | R_OUT | Y_IN));
    step();
    chk("add_t4", ex(4'h2, GRC | R_OUT | Z_IN));
    stop = 1'b1;
    step();
    chk("add_t5", ex(4'h0, Z_LOW_OUT | GRA | R_IN));
    step();
    chk("pause", 32'h0);
    step();
    chk("pause_hold", 32'h0);
    stop = 1'b0;
    step();

    fetch(32'h6800_0000, "ori");
    chk("ori_t3", ex(4'h0, GRB | R_OUT | Y_IN));
    step();
    chk("ori_t4", ex(4'h1, C_OUT | Z_IN));
    step();
    chk("ori_t5", ex(4'h0, Z_LOW_OUT | GRA | R_IN));
    step();

    fetch(32'h8000_0000, "neg");
    chk("neg_t3", ex(4'hA, GRB | R_OUT | Z_IN));
    step();
    chk("neg_t4", ex(4'h0, Z_LOW_OUT | GRA | R_IN));
    step();

    fetch(32'h7000_0000, "mul");
`ifdef CU_MULDIV_EN
    chk("mul_t3", ex(4'h0, GRA | R_OUT | Y_IN));
    step();
    chk("mul_t4", ex(4'h8, GRB | R_OUT | Z_IN));
    step();
    chk("mul_t5", ex(4'h0, Z_LOW_OUT | LO_IN));
    step();
    chk("mul_t6", ex(4'h0, Z_HIGH_OUT | HI_IN));
    step();
`endif

    fetch(32'hB800_0000, "mfhi");
    chk("mfhi_t3", ex(4'h0, HI_OUT | GRA | R_IN));
    step();

    fetch(32'hA800_0000, "in");
    chk("in_t3", ex(4'h0, INPORT_OUT | GRA | R_IN));
    step();

    fetch(32'h1800_0000, "add2");
    step();
    chk("add2_t4", ex(4'h2, GRC | R_OUT | Z_IN));
    reset_n = 1'b0;
    #1;
    chk("rst_async", 32'h0);
    step();
    chk("rst_hold", 32'h0);
    stop    = 1'b1;
    reset_n = 1'b1;
    step();
    chk("rst_pause", 32'h0);
    stop = 1'b0;
    step();

    fetch(32'hD000_0000, "halt");
    chk("halted", 32'h0);
    step();
    step();
    chk("halted_hold", 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired sequencer for the ezRISC datapath. It is a Moore FSM that issues the datapath control strobes for instruction fetch (T0–T2) and for each instruction's execute steps (T3–T7), based on the opcode in the instruction register. It sits beside `datapath` in the CPU top level: its outputs drive `datapath` control ports one-for-one, and it reads back `ir` and `con_out`.

## Interface
Parameters:
- `OPC_W`, default 5: opcode width, taken from `ir[31:27]`.

Ports:
- `clk` in 1: system clock. All state changes occur on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ir` in 32: instruction register contents.
- `con_out` in 1: branch condition from the datapath.
- `stop` in 1: pause request, honoured only at instruction boundaries.
- `run` out 1: 1 while executing; 0 in RESET, PAUSE and HALTED.
- Strobe outputs, 1 bit each, same names as the `datapath` ports: `pc_out`, `pc_in`, `inc_pc`, `mar_in`, `mdr_in`, `mdr_out`, `read`, `write`, `ir_in`, `y_in`, `z_in`, `z_low_out`, `z_high_out`, `hi_in`, `hi_out`, `lo_in`, `lo_out`, `gra`, `grb`, `grc`, `r_in`, `r_out`, `ba_out`, `c_out`, `con_in`, `inport_out`, `outport_in`.
- `alu_op` out 4: ALU operation code. And=0, Or=1, Add=2, Sub=3, Shr=4, Shl=5, Ror=6, Rol=7, Mul=8, Div=9, Neg=A, Not=B.

## Operation
- States: RESET, PAUSE, T0…T7, HALTED. Every output is a pure decode of the state register and the latched opcode. In RESET all outputs are 0 and `alu_op` is 0.
- Fetch:
  - T0: `pc_out mar_in inc_pc z_in`, `alu_op`=Add.
  - T1: `z_low_out pc_in read mdr_in`.
  - T2: `mdr_out ir_in`.
- At the T2→T3 edge, the opcode is latched from `ir[31:27]`. This value is valid because `ir_in` was asserted during T2.
- Execute steps (last listed step returns to T0):
  - R-type ALU ops (add 3, sub 4, shr 5, shl 6, ror 7, rol 8, and 9, or 10):
    - T3: `grb r_out y_in`.
    - T4: `grc r_out z_in`, `alu_op`=op.
    - T5: `z_low_out gra r_in`.
  - addi 11, andi 12, ori 13:
    - T3: `grb r_out y_in`.
    - T4: `c_out z_in`, `alu_op`=Add/And/Or.
    - T5: `z_low_out gra r_in`.
  - ld 0:
    - T3: `grb ba_out y_in`.
    - T4: `c_out z_in`, `alu_op`=Add.
    - T5: `z_low_out mar_in`.
    - T6: `read mdr_in`.
    - T7: `mdr_out gra r_in`.
  - ldi 1: ld T3–T4, then T5: `z_low_out gra r_in`.
  - st 2:
    - T3–T5: as ld.
    - T6: `gra r_out mdr_in`.
    - T7: `write`.
  - neg 16, not 17:
    - T3: `grb r_out z_in`, `alu_op`=Neg/Not.
    - T4: `z_low_out gra r_in`.
  - br 18:
    - T3: `gra r_out con_in`.
    - T4: `pc_out y_in`.
    - T5: `c_out z_in`, `alu_op`=Add.
    - T6: `z_low_out pc_in` only if `con_out`=1. T6 is a dead step otherwise.
  - jr 19, T3: `gra r_out pc_in`.
  - in 21, T3: `inport_out gra r_in`.
  - out 22, T3: `gra r_out outport_in`.
  - mfhi 23, T3: `hi_out gra r_in`.
  - mflo 24, T3: `lo_out gra r_in`.
  - nop 25, jal 20, and opcodes 27–31: no execute step. T2 goes directly to T0.
  - halt 26: T2 → HALTED. HALTED asserts no strobes. It is left only through reset.
- Boundary (state entered after the last execute step, before T0): if `stop`=1, go to PAUSE. PAUSE returns to T0 on the first cycle with `stop`=0. `stop` is ignored mid-instruction.
- Reset asserted in any state: state goes immediately to RESET and all outputs go to 0. RESET → T0 on the first clock after release (→ PAUSE if `stop`=1).

## Timing
- One step per clock cycle. Outputs change only after a rising edge, or asynchronously on reset.
- Fetch is 3 cycles. Instruction length: jr/in/out/mfhi/mflo 4, neg/not 5, ALU/imm/ldi 6, br 7, ld/st 8, nop 3. mul/div is 7 when enabled.
- `con_out` is sampled combinationally during T6 of br. `con_in` in T3 guarantees it is stable by then.
- `read` and `mdr_in` are asserted together for exactly one cycle. Memory returns data within that cycle.

## Configuration
- `CU_MULDIV_EN` defined: mul 14 and div 15 execute as follows, then return to T0.
  - T3: `gra r_out y_in`.
  - T4: `grb r_out z_in`, `alu_op`=Mul/Div.
  - T5: `z_low_out lo_in`.
  - T6: `z_high_out hi_in`.
- Undefined: opcodes 14 and 15 behave as nop. `alu_op` values 8 and 9 are never issued.

## Structure
- Package `cu_pkg`: opcode localparams (5-bit), `alu_op` codes, and the state encoding. `datapath` testbenches share the `alu_op` codes.
- Sub-module `cu_decode` (combinational): maps {state, opcode, `con_out`} to the strobe vector. `control_unit` holds the state register, the opcode latch and the `stop` logic.

## Test plan
- Reset, then release with `stop`=0 → T0 strobes on the first cycle: `pc_out`=`mar_in`=`inc_pc`=`z_in`=1, `alu_op`=2.
- `ir`=0x98800000 (jr R1) → T3 asserts `gra`, `r_out`, `pc_in`, then the next cycle is T0. Instruction takes 4 cycles total.
- br, once with `con_out`=1 and once with 0 → `pc_in` asserted in T6 only in the first case. Both return to T0 after 7 cycles.
- `ir`=0x00000000 (ld) → `read`+`mdr_in` in T6 and `mdr_out`+`gra`+`r_in` in T7. st (0x10000000) → `write` in T7 only.
- `stop` raised during T4 of add → instruction completes, then PAUSE with `run`=0. Lowering `stop` → T0.
- halt (0xD0000000) → HALTED, all strobes 0. Reset asserted during T4 of add → all outputs 0 immediately. Mul opcode without `CU_MULDIV_EN` → 3-cycle nop.
